golomb_decoder: RTL and testbench
=================================

Name: golomb_decoder

Overview:
- Receive-side counterpart of the Golomb-Rice block encoder.
- Accepts the serialized compressed byte stream (e.g. from the UART receive path) and parses it bit by bit.
- Rebuilds each block of N signed-magnitude samples plus its mode bit, and hands each finished block downstream with a valid/ack handshake.
- After D blocks it discards the final byte padding and signals completion.

Parameters:
- W, 8, magnitude bits per sample; each sample is W+1 bits with the sign at bit W.
- N, 16, samples per block.
- LOGN, 4, width of the sample index.
- R, 2, Rice remainder bits; quotient is W-R bits.
- D, 8, blocks per stream.
- LOGD, 3, block counter width is LOGD+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_byte  input  W  next compressed byte, transmitted LSB-first.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  decoder can accept a byte this cycle.
- block_out  output  N*(W+1)  decoded block; sample 0 in bits [N*(W+1)-1 -: W+1], sample N-1 in the LSBs.
- mode_out  output  1  mode bit of the block.
- block_valid  output  1  block_out/mode_out hold a complete block.
- block_ack  input  1  downstream accepts the block.
- blocks_left  output  LOGD+1  blocks still to decode; reset value D.
- all_done  output  1  sticky; all D blocks delivered and padding flushed.
- err  output  1  sticky; illegal unary quotient detected.

Behaviour:
- Reset (async, rst low), in any state including mid-byte or mid-block:
  - all outputs 0 except blocks_left=D;
  - bit buffer emptied; state S_MODE.
- Bit buffer:
  - in_ready = (bits_left==0) and state not in {S_DONE, S_ERR, S_OUT}.
  - On in_valid & in_ready, the byte is latched and bits_left=W.
  - Each parsing cycle with bits_left!=0 consumes buffer bit 0, shifts the buffer right and decrements bits_left.
  - No parsing happens in the load cycle, so peak throughput is W bits per W+1 cycles.
  - in_valid with in_ready low is ignored; the source must hold the byte.
- Bitstream per block, continuous across blocks with no byte alignment:
  - mode: 1 bit.
  - Sample 0: W bits, MSB first; its sign is not sent and is decoded as 0.
  - Samples 1..N-1, each as:
    - sign: 1 bit;
    - quotient q = value[W-1:R] in unary: q zeros, then a single 1;
    - remainder: R bits, MSB first.
  - Reconstructed sample = {sign, q, rem}.
- States; each bit state advances only in cycles where a bit is consumed:
  - S_MODE: latch mode, go to S_FIRST with cnt=W-1.
  - S_FIRST: shift the bit into the sample; after cnt==0, store sample 0 and go to S_SIGN.
  - S_SIGN: latch sign, q=0, go to S_UNARY.
  - S_UNARY:
    - bit 0 increments q;
    - bit 1 goes to S_REM with cnt=R-1;
    - bit 0 while q==2^(W-R)-1 goes to S_ERR.
  - S_REM: shift rem. After the last bit:
    - write the sample into block_out at the current index;
    - if index==N-1 go to S_OUT, else go to S_SIGN.
  - S_OUT:
    - block_valid=1, blocks_left decremented on entry;
    - block_out and mode_out stay stable until block_valid & block_ack.
    - In that ack cycle block_valid drops; the next state is S_FLUSH if blocks_left==0, else S_MODE.
    - Unconsumed buffered bits are kept for the next block.
  - S_FLUSH: discard the remaining bits_left pad bits (values ignored), then go to S_DONE.
  - S_DONE: all_done=1, in_ready=0, terminal until reset.
  - S_ERR: err=1, in_ready=0, block_valid=0, terminal until reset.
- block_out samples are updated only while a block is being parsed, never during S_OUT.
- block_ack while block_valid=0 is ignored.

Test Plan:
- Parameter D=1; send bytes 0x4B,0x45,0x44,0x44,0x44,0x44,0x44,0x44,0x04 -> one block_valid with mode_out=1, sample0=9'h0A5, samples1..15=0; after ack, all_done=1, blocks_left=0, in_ready=0.
- Sample 1 encoded as bits 1,0,0,0,1,0,1 (sign 1, q=3, rem 01) -> word 1 of block_out = 9'h10D; other words match the encoded values.
- Hold block_ack low 20 cycles after block_valid -> block_out/mode_out unchanged, no bytes accepted; block_valid falls the cycle after ack; the next block decodes correctly from the leftover mid-byte bits.
- 64 consecutive zero bits inside a quotient -> err=1 after the 64th zero, in_ready=0, block_valid never asserts.
- Default D=8 stream of 8 random encoded blocks with zero padding -> 8 blocks bit-exact, blocks_left counts 8 down to 0, all_done after the pad bits are consumed.
- Assert rst mid-sample, then resend a fresh stream -> outputs return to reset values immediately; the new stream decodes correctly.

Source files
------------

// File: rtl/golomb_decoder.sv
// Golomb-Rice block decoder: parses a serialized LSB-first byte stream bit by
// bit, rebuilds blocks of N signed-magnitude samples plus a mode bit, hands
// each block downstream over a valid/ack handshake and, after D blocks,
// discards the trailing byte padding before signalling completion.
module golomb_decoder #(
    parameter int W    = 8,
    parameter int N    = 16,
    parameter int LOGN = 4,
    parameter int R    = 2,
    parameter int D    = 8,
    parameter int LOGD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*(W+1)-1:0]   block_out,
    output logic                 mode_out,
    output logic                 block_valid,
    input  logic                 block_ack,
    output logic [LOGD:0]        blocks_left,
    output logic                 all_done,
    output logic                 err
);
    localparam int BW = N * (W + 1);
    localparam int CW = $clog2(W + 1);
    localparam int QW = W - R;
    localparam int LW = LOGD + 1;
    localparam logic [BW-1:0] WMASK = {{(BW - W - 1){1'b0}}, {(W + 1){1'b1}}};

    typedef enum logic [3:0] {
        S_MODE, S_FIRST, S_SIGN, S_UNARY, S_REM, S_OUT, S_FLUSH, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    buf_q, buf_d;
    logic [CW-1:0]   bits_left_q, bits_left_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    samp_q, samp_d;
    logic            sign_q, sign_d;
    logic [QW-1:0]   q_q, q_d;
    logic [R-1:0]    rem_q, rem_d;
    logic [LOGN-1:0] idx_q, idx_d;
    logic [BW-1:0]   block_q, block_d;
    logic            mode_q, mode_d;
    logic [LW-1:0]   left_q, left_d;

    logic            bit_av;
    logic            bit_in;
    logic            take;
    logic            consume;
    logic            wr_en;
    logic [W:0]      wr_sample;
    logic [W-1:0]    samp_next;
    logic [R-1:0]    rem_next;
    int              wr_sh;

    assign bit_av    = (bits_left_q != '0);
    assign bit_in    = buf_q[0];
    assign in_ready  = (bits_left_q == '0) && !(state_q inside {S_DONE, S_ERR, S_OUT});
    assign take      = in_valid && in_ready;
    assign samp_next = W'({samp_q, bit_in});
    assign rem_next  = R'({rem_q, bit_in});
    // Sample 0 sits in the MSBs, sample N-1 in the LSBs.
    assign wr_sh     = (N - 1 - int'(idx_q)) * (W + 1);

    assign block_out   = block_q;
    assign mode_out    = mode_q;
    assign block_valid = (state_q == S_OUT);
    assign blocks_left = left_q;
    assign all_done    = (state_q == S_DONE);
    assign err         = (state_q == S_ERR);

    // Parser next state: each bit state advances only when a buffered bit is consumed.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        bits_left_d = bits_left_q;
        cnt_d       = cnt_q;
        samp_d      = samp_q;
        sign_d      = sign_q;
        q_d         = q_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        block_d     = block_q;
        mode_d      = mode_q;
        left_d      = left_q;
        consume     = 1'b0;
        wr_en       = 1'b0;
        wr_sample   = '0;

        unique case (state_q)
            S_MODE: begin
                if (bit_av) begin
                    consume = 1'b1;
                    mode_d  = bit_in;
                    idx_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                if (bit_av) begin
                    consume = 1'b1;
                    samp_d  = samp_next;
                    if (cnt_q == '0) begin
                        // Sample 0 carries no sign bit on the wire.
                        wr_en     = 1'b1;
                        wr_sample = {1'b0, samp_next};
                        idx_d     = idx_q + LOGN'(1);
                        state_d   = S_SIGN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_SIGN: begin
                if (bit_av) begin
                    consume = 1'b1;
                    sign_d  = bit_in;
                    q_d     = '0;
                    state_d = S_UNARY;
                end
            end
            S_UNARY: begin
                if (bit_av) begin
                    consume = 1'b1;
                    if (bit_in) begin
                        cnt_d   = CW'(R - 1);
                        state_d = S_REM;
                    end else if (q_q == '1) begin
                        // One more zero would overflow the quotient field.
                        state_d = S_ERR;
                    end else begin
                        q_d = q_q + QW'(1);
                    end
                end
            end
            S_REM: begin
                if (bit_av) begin
                    consume = 1'b1;
                    rem_d   = rem_next;
                    if (cnt_q == '0) begin
                        wr_en     = 1'b1;
                        wr_sample = {sign_q, q_q, rem_next};
                        if (idx_q == LOGN'(N - 1)) begin
                            left_d  = left_q - LW'(1);
                            state_d = S_OUT;
                        end else begin
                            idx_d   = idx_q + LOGN'(1);
                            state_d = S_SIGN;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_OUT: begin
                // Leftover buffered bits stay put for the next block.
                if (block_ack) begin
                    state_d = (left_q == '0) ? S_FLUSH : S_MODE;
                end
            end
            S_FLUSH: begin
                consume = bit_av;
                if (bits_left_q <= CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_MODE;
            end
        endcase

        // Load and consume never coincide: loading requires an empty buffer.
        if (take) begin
            buf_d       = in_byte;
            bits_left_d = CW'(W);
        end else if (consume) begin
            buf_d       = buf_q >> 1;
            bits_left_d = bits_left_q - CW'(1);
        end

        if (wr_en) begin
            block_d = (block_q & ~(WMASK << wr_sh)) | (BW'(wr_sample) << wr_sh);
        end
    end

    // State, bit buffer and block registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_MODE;
            buf_q       <= '0;
            bits_left_q <= '0;
            cnt_q       <= '0;
            samp_q      <= '0;
            sign_q      <= 1'b0;
            q_q         <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            block_q     <= '0;
            mode_q      <= 1'b0;
            left_q      <= LW'(D);
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            bits_left_q <= bits_left_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            sign_q      <= sign_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            block_q     <= block_d;
            mode_q      <= mode_d;
            left_q      <= left_d;
        end
    end
endmodule

// File: tb/tb_golomb_decoder.sv
// Bench for golomb_decoder: a D=1 instance fed the literal reference stream and
// a D=8 instance fed table-driven, random, error and mid-stream-reset streams.
module tb_golomb_decoder;
    localparam int W    = 8;
    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int R    = 2;
    localparam int LOGD = 3;
    localparam int W1   = W + 1;
    localparam int BW   = N * W1;
    localparam int LIM  = 4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][W-1:0]  in_byte;
    logic [1:0]         in_valid, in_ready, mode_out, block_valid, block_ack, all_done, err;
    logic [1:0][BW-1:0] block_out;
    logic [1:0][LOGD:0] blocks_left;

    golomb_decoder #(.W(W), .N(N), .LOGN(LOGN), .R(R), .D(1), .LOGD(LOGD)) u_d1 (
        .clk(clk), .rst(rst), .in_byte(in_byte[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .block_out(block_out[0]), .mode_out(mode_out[0]),
        .block_valid(block_valid[0]), .block_ack(block_ack[0]),
        .blocks_left(blocks_left[0]), .all_done(all_done[0]), .err(err[0]));

    golomb_decoder #(.W(W), .N(N), .LOGN(LOGN), .R(R), .D(8), .LOGD(LOGD)) u_d8 (
        .clk(clk), .rst(rst), .in_byte(in_byte[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .block_out(block_out[1]), .mode_out(mode_out[1]),
        .block_valid(block_valid[1]), .block_ack(block_ack[1]),
        .blocks_left(blocks_left[1]), .all_done(all_done[1]), .err(err[1]));

    typedef struct packed {
        logic          mode;
        logic [BW-1:0] blk;
    } exp_t;

    typedef struct {
        logic          mode;
        logic [W:0]    s0;
        logic [W:0]    s1;
        logic [W:0]    fill;
        logic [W:0]    last;
        int            dly;
        logic [BW-1:0] want;
    } vec_t;

    exp_t       sb[$];
    bit         bits[$];
    logic [7:0] bytes[$];
    vec_t       tbl[8];
    int         dly[8];
    int         checks = 0;
    int         failures = 0;
    int         n0 = 0;

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=no event required=event within %0d cycles", nm, LIM);
    endtask

    function automatic logic [BW-1:0] mk_blk(input logic [W:0] s0, input logic [W:0] s1,
                                             input logic [W:0] fill, input logic [W:0] last);
        logic [BW-1:0] b;
        logic [W:0]    s;
        b = '0;
        for (int k = 0; k < N; k++) begin
            s = (k == 0) ? s0 : (k == 1) ? s1 : (k == N - 1) ? last : fill;
            b = (b << W1) | BW'(s);
        end
        return b;
    endfunction

    function automatic logic [W:0] samp(input logic [BW-1:0] b, input int k);
        return W1'(b >> ((N - 1 - k) * W1));
    endfunction

    task automatic push_msb(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits.push_back(1'(v >> i));
    endtask

    // Reference encoder: appends one block to the bit stream and its expected decode to the scoreboard.
    task automatic enc_block(input logic mode, input logic [BW-1:0] blk);
        logic [W:0]    s;
        logic [BW-1:0] e;
        int            q;
        bits.push_back(mode);
        s = samp(blk, 0);
        push_msb(32'(s[W-1:0]), W);
        for (int k = 1; k < N; k++) begin
            s = samp(blk, k);
            bits.push_back(s[W]);
            q = int'(s[W-1:R]);
            repeat (q) bits.push_back(1'b0);
            bits.push_back(1'b1);
            push_msb(32'(s[R-1:0]), R);
        end
        e = blk;
        e[BW-1] = 1'b0;
        sb.push_back('{mode, e});
    endtask

    task automatic pack();
        logic [7:0] b;
        while (bits.size() > 0) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                b = b >> 1;
                if (bits.size() > 0) b[7] = bits.pop_front();
            end
            bytes.push_back(b);
        end
    endtask

    task automatic rand_stream(input logic [W:0] first_s0);
        logic [BW-1:0] b;
        logic [W:0]    s;
        for (int i = 0; i < 8; i++) begin
            b = '0;
            for (int k = 0; k < N; k++) begin
                s = W1'($urandom);
                if (i == 0 && k == 0) s = first_s0;
                b = (b << W1) | BW'(s);
            end
            enc_block(1'($urandom), b);
            dly[i] = int'($urandom_range(0, 3));
            if (i == 0) n0 = bits.size();
        end
        pack();
    endtask

    task automatic feed(input int u, input int nmax);
        int t;
        int sent;
        sent = 0;
        while (bytes.size() > 0 && sent < nmax) begin
            in_byte[u]  = bytes.pop_front();
            in_valid[u] = 1'b1;
            t = 0;
            while (!in_ready[u] && t < LIM) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready[u]) begin
                tmo("feed_ready");
                break;
            end
            @(negedge clk);
            sent++;
        end
        in_valid[u] = 1'b0;
    endtask

    task automatic consume(input int u, input int nblk, input int dmax);
        exp_t e;
        int   t;
        bit   bad;
        for (int b = 0; b < nblk; b++) begin
            t = 0;
            while (!block_valid[u] && t < LIM) begin
                @(negedge clk);
                t++;
            end
            if (!block_valid[u]) begin
                tmo("block_valid");
                return;
            end
            if (sb.size() == 0) begin
                tmo("scoreboard_empty");
                return;
            end
            e = sb.pop_front();
            check("block_out", block_out[u], e.blk);
            check("mode_out", BW'(mode_out[u]), BW'(e.mode));
            check("blocks_left", BW'(blocks_left[u]), BW'(dmax - 1 - b));
            bad = 1'b0;
            for (int i = 0; i < dly[b]; i++) begin
                @(negedge clk);
                if (!block_valid[u] || block_out[u] !== e.blk || mode_out[u] !== e.mode || in_ready[u])
                    bad = 1'b1;
            end
            if (dly[b] > 0) check("hold_stable", BW'(bad), BW'(0));
            block_ack[u] = 1'b1;
            @(negedge clk);
            block_ack[u] = 1'b0;
            check("valid_drop", BW'(block_valid[u]), BW'(0));
            // A stray ack with no block pending must have no effect.
            block_ack[u] = 1'b1;
            @(negedge clk);
            block_ack[u] = 1'b0;
        end
    endtask

    task automatic wait_done(input int u);
        int t;
        t = 0;
        while (!all_done[u] && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("all_done", BW'(all_done[u]), BW'(1));
        check("blocks_left_end", BW'(blocks_left[u]), BW'(0));
        check("in_ready_done", BW'(in_ready[u]), BW'(0));
        check("err_clear", BW'(err[u]), BW'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '0;
        block_ack = '0;
        bytes.delete();
        sb.delete();
        bits.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  t;
        bit  seen;
        int  k;
        in_valid  = '0;
        block_ack = '0;
        in_byte   = '0;

        tbl[0] = '{mode:1'b1, s0:9'h0A5, s1:9'h000, fill:9'h000, last:9'h000, dly:0,  want:'0};
        tbl[1] = '{mode:1'b0, s0:9'h000, s1:9'h10D, fill:9'h003, last:9'h1FF, dly:20, want:'0};
        tbl[2] = '{mode:1'b1, s0:9'h0FF, s1:9'h100, fill:9'h0FF, last:9'h001, dly:3,  want:'0};
        tbl[3] = '{mode:1'b0, s0:9'h080, s1:9'h1FC, fill:9'h104, last:9'h0FC, dly:1,  want:'0};
        tbl[4] = '{mode:1'b1, s0:9'h000, s1:9'h000, fill:9'h000, last:9'h000, dly:0,  want:'0};
        tbl[5] = '{mode:1'b1, s0:9'h07F, s1:9'h081, fill:9'h1AA, last:9'h055, dly:0,  want:'0};
        tbl[6] = '{mode:1'b0, s0:9'h001, s1:9'h0C0, fill:9'h010, last:9'h1FE, dly:2,  want:'0};
        tbl[7] = '{mode:1'b1, s0:9'h0AA, s1:9'h155, fill:9'h07F, last:9'h180, dly:5,  want:'0};
        for (int i = 0; i < 8; i++) tbl[i].want = mk_blk(tbl[i].s0, tbl[i].s1, tbl[i].fill, tbl[i].last);

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_block_out", block_out[u], '0);
            check("rst_mode_out", BW'(mode_out[u]), BW'(0));
            check("rst_block_valid", BW'(block_valid[u]), BW'(0));
            check("rst_all_done", BW'(all_done[u]), BW'(0));
            check("rst_err", BW'(err[u]), BW'(0));
            check("rst_blocks_left", BW'(blocks_left[u]), BW'((u == 0) ? 1 : 8));
        end
        rst = 1'b1;
        @(negedge clk);

        // D=1 instance: literal reference stream.
        bytes = '{8'h4B, 8'h45, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h04};
        sb.push_back('{1'b1, mk_blk(9'h0A5, 9'h000, 9'h000, 9'h000)});
        dly = '{0, 0, 0, 0, 0, 0, 0, 0};
        fork
            feed(0, 100);
            consume(0, 1, 1);
        join
        wait_done(0);

        // D=8 instance: table-driven stream, including a 20-cycle ack hold.
        for (int i = 0; i < 8; i++) begin
            enc_block(tbl[i].mode, tbl[i].want);
            dly[i] = tbl[i].dly;
        end
        pack();
        fork
            feed(1, 100000);
            consume(1, 8, 8);
        join
        wait_done(1);

        // Random stream.
        do_reset();
        rand_stream(W1'($urandom));
        fork
            feed(1, 100000);
            consume(1, 8, 8);
        join
        wait_done(1);

        // Quotient overflow: 64 zeros after a sign bit.
        do_reset();
        bits.push_back(1'b1);
        push_msb(32'h5A, W);
        bits.push_back(1'b1);
        repeat (64) bits.push_back(1'b0);
        pack();
        seen = 1'b0;
        t = 0;
        fork
            feed(1, 100);
            begin
                while (!err[1] && t < LIM) begin
                    seen = seen | block_valid[1];
                    @(negedge clk);
                    t++;
                end
            end
        join
        check("err_set", BW'(err[1]), BW'(1));
        check("err_in_ready", BW'(in_ready[1]), BW'(0));
        check("err_no_block", BW'(seen), BW'(0));
        repeat (10) begin
            seen = seen | block_valid[1];
            @(negedge clk);
        end
        check("err_sticky", BW'(err[1]), BW'(1));
        check("err_no_block_after", BW'(seen | block_valid[1]), BW'(0));

        // Asynchronous reset in the middle of the second block, then a fresh stream.
        do_reset();
        rand_stream(9'h0C3);
        k = (n0 + 7) / 8 + 2;
        dly[0] = 0;
        fork
            feed(1, k);
            consume(1, 1, 8);
        join
        check("pre_reset_blocks_left", BW'(blocks_left[1]), BW'(7));
        #2 rst = 1'b0;
        #1;
        check("midrst_block_out", block_out[1], '0);
        check("midrst_mode_out", BW'(mode_out[1]), BW'(0));
        check("midrst_block_valid", BW'(block_valid[1]), BW'(0));
        check("midrst_blocks_left", BW'(blocks_left[1]), BW'(8));
        check("midrst_done_err", BW'({all_done[1], err[1]}), BW'(0));
        bytes.delete();
        sb.delete();
        bits.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rand_stream(W1'($urandom));
        fork
            feed(1, 100000);
            consume(1, 8, 8);
        join
        wait_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
